// File: rtl/spi_globals_pkg.sv
// ============================================================================
// Module : spi_globals_pkg
// Brief  : Shared types and defaults for the SPI slave responder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package spi_globals_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_ACTIVE       = 2'd1,
        ST_WAIT_CS_HIGH = 2'd2
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
        logic msb_first;
    } spi_mode_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync_edge_detect.sv
// ============================================================================
// Module : spi_sync_edge_detect
// Brief  : Two-flop synchronizer with registered rise/fall pulse outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_sync_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pin_sync,
    output logic pin_rise,
    output logic pin_fall
);

    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [2:0] r_sync;
    logic       r_rise;
    logic       r_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 3'b000;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[1:0], pin};
            r_rise <= r_sync[1] & ~r_sync[2];
            r_fall <= ~r_sync[1] & r_sync[2];
        end
    end

    assign pin_sync = r_sync[1];
    assign pin_rise = r_rise;
    assign pin_fall = r_fall;

endmodule

`default_nettype wire

// File: rtl/spi_slave_responder.sv
// ============================================================================
// Module : spi_slave_responder
// Brief  : Oversampled SPI slave, all CPOL/CPHA modes, MSB/LSB first.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module spi_slave_responder
    import spi_globals_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  msb_first,
    input  logic                  sclk,
    input  logic                  cs,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  tx_underrun,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_error
);

    localparam int                c_cnt_w    = $clog2(DATA_WIDTH);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(DATA_WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs_sync, w_cs_rise, w_cs_fall;

    spi_sync_edge_detect u_sclk_sync (
        .clk      (pclk),
        .rst      (areset),
        .pin      (sclk),
        .pin_sync (w_sclk_sync),
        .pin_rise (w_sclk_rise),
        .pin_fall (w_sclk_fall)
    );

    spi_sync_edge_detect u_cs_sync (
        .clk      (pclk),
        .rst      (areset),
        .pin      (cs),
        .pin_sync (w_cs_sync),
        .pin_rise (w_cs_rise),
        .pin_fall (w_cs_fall)
    );

    spi_state_e            r_state, w_next_state;
    spi_mode_t             r_mode, w_mode_in;
    logic                  r_mosi_meta, r_mosi_sync;
    logic [DATA_WIDTH-1:0] r_rx_shift, r_rx_data, w_rx_next;
    logic [DATA_WIDTH-1:0] r_tx_shift, w_tx_next, w_load_word;
    logic [c_cnt_w-1:0]    r_rx_cnt, r_tx_cnt;
    logic                  r_rx_valid, r_frame_error, r_miso, r_miso_oe;

    logic w_lead, w_trail, w_sample_pulse, w_shift_pulse, w_load_msb;
    logic w_start, w_end, w_sample, w_load, w_shift_next;
    logic w_tx_ready, w_tx_underrun;

    assign w_mode_in      = '{cpol: cpol, cpha: cpha, msb_first: msb_first};
    assign w_lead         = r_mode.cpol ? w_sclk_fall : w_sclk_rise;
    assign w_trail        = r_mode.cpol ? w_sclk_rise : w_sclk_fall;
    assign w_sample_pulse = r_mode.cpha ? w_trail : w_lead;
    assign w_shift_pulse  = r_mode.cpha ? w_lead  : w_trail;

    // The cpha=0 preload happens in IDLE, before the mode register is captured
    assign w_load_msb  = (r_state == ST_IDLE) ? msb_first : r_mode.msb_first;
    assign w_load_word = tx_valid ? tx_data : '0;

    assign w_rx_next = r_mode.msb_first ? {r_rx_shift[DATA_WIDTH-2:0], r_mosi_sync}
                                        : {r_mosi_sync, r_rx_shift[DATA_WIDTH-1:1]};
    assign w_tx_next = r_mode.msb_first ? {r_tx_shift[DATA_WIDTH-2:0], 1'b0}
                                        : {1'b0, r_tx_shift[DATA_WIDTH-1:1]};

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            r_state <= ST_WAIT_CS_HIGH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT_CS_HIGH: if (w_cs_sync) w_next_state = ST_IDLE;
            ST_IDLE:         if (w_cs_fall) w_next_state = ST_ACTIVE;
            ST_ACTIVE:       if (w_cs_rise) w_next_state = ST_IDLE;
            default:         w_next_state = ST_WAIT_CS_HIGH;
        endcase
    end

    // cs rise has priority over any coincident sclk edge
    always_comb begin
        w_start      = 1'b0;
        w_end        = 1'b0;
        w_sample     = 1'b0;
        w_load       = 1'b0;
        w_shift_next = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_cs_fall) begin
                    w_start = 1'b1;
                    w_load  = ~cpha;
                end
            end
            ST_ACTIVE: begin
                if (w_cs_rise) begin
                    w_end = 1'b1;
                end else begin
                    w_sample     = w_sample_pulse;
                    w_load       = w_shift_pulse & (r_tx_cnt == '0);
                    w_shift_next = w_shift_pulse & (r_tx_cnt != '0);
                end
            end
            default: ;
        endcase
        w_tx_ready    = w_load & tx_valid;
        w_tx_underrun = w_load & ~tx_valid;
    end

    always_ff @(posedge pclk or posedge areset) begin
        if (areset) begin
            r_mode        <= '0;
            r_mosi_meta   <= 1'b0;
            r_mosi_sync   <= 1'b0;
            r_rx_shift    <= '0;
            r_rx_data     <= '0;
            r_rx_cnt      <= '0;
            r_rx_valid    <= 1'b0;
            r_tx_shift    <= '0;
            r_tx_cnt      <= '0;
            r_miso        <= 1'b0;
            r_miso_oe     <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_mosi_meta   <= mosi;
            r_mosi_sync   <= r_mosi_meta;
            r_rx_valid    <= 1'b0;
            r_frame_error <= 1'b0;

            if (w_start) begin
                r_mode    <= w_mode_in;
                r_miso_oe <= 1'b1;
                r_rx_cnt  <= '0;
                r_tx_cnt  <= '0;
            end

            if (w_sample) begin
                r_rx_shift <= w_rx_next;
                if (r_rx_cnt == c_last_bit) begin
                    r_rx_data  <= w_rx_next;
                    r_rx_valid <= 1'b1;
                    r_rx_cnt   <= '0;
                end else begin
                    r_rx_cnt <= r_rx_cnt + c_one;
                end
            end

            if (w_load) begin
                r_tx_shift <= w_load_word;
                r_miso     <= w_load_msb ? w_load_word[DATA_WIDTH-1] : w_load_word[0];
                r_tx_cnt   <= c_one;
            end else if (w_shift_next) begin
                r_tx_shift <= w_tx_next;
                r_miso     <= r_mode.msb_first ? w_tx_next[DATA_WIDTH-1] : w_tx_next[0];
                r_tx_cnt   <= (r_tx_cnt == c_last_bit) ? '0 : r_tx_cnt + c_one;
            end

            // Partial words are dropped, along with any preloaded tx word
            if (w_end) begin
                r_frame_error <= (r_rx_cnt != '0);
                r_rx_cnt      <= '0;
                r_tx_cnt      <= '0;
                r_tx_shift    <= '0;
                r_miso        <= 1'b0;
                r_miso_oe     <= 1'b0;
            end
        end
    end

    assign miso        = r_miso;
    assign miso_oe     = r_miso_oe;
    assign tx_ready    = w_tx_ready;
    assign tx_underrun = w_tx_underrun;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign frame_error = r_frame_error;

endmodule

`default_nettype wire

// File: doc/spi_slave_responder.md
# spi_slave_responder

Synthesizable SPI slave (responder) endpoint: the far end of the SPI master driver, receiving MOSI and returning MISO for all four CPOL/CPHA modes, MSB- or LSB-first. It oversamples the SPI pins on the system clock, deserializes each received word, and serializes a word from a valid/ready transmit source. It serves as the DUT-side loopback target in the hdl_top for closed-loop master-agent regression.

## Interface
- DATA_WIDTH, 8: bits per SPI word (≥2).
- pclk  in  1  system clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- cpol  in  1  clock idle level; captured at frame start.
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge; captured at frame start.
- msb_first  in  1  bit order for both directions; captured at frame start.
- sclk  in  1  SPI clock, asynchronous to pclk.
- cs  in  1  chip select, active low, asynchronous.
- mosi  in  1  serial data from master.
- miso  out  1  serial data to master; 0 while idle.
- miso_oe  out  1  high while a frame is active (external tristate control).
- tx_data  in  DATA_WIDTH  next word to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  one-cycle pulse: tx_data consumed this cycle.
- tx_underrun  out  1  one-cycle pulse: load occurred with tx_valid low.
- rx_data  out  DATA_WIDTH  last complete received word; held until next completes.
- rx_valid  out  1  one-cycle pulse: rx_data updated.
- frame_error  out  1  one-cycle pulse: cs deasserted mid-word.

## Operation
- sclk, cs, mosi pass through 2-flop synchronizers; registered edge detect yields one-cycle pulses.
- Leading edge = rising if cpol=0, falling if cpol=1. Sample edge = leading (cpha=0) or trailing (cpha=1); shift edge = the other.
- FSM: IDLE, ACTIVE, WAIT_CS_HIGH.
  - IDLE: on cs fall → capture cpol/cpha/msb_first, assert miso_oe, go ACTIVE; if cpha=0, load immediately.
  - ACTIVE: sample edge shifts synchronized mosi into rx shifter, increments bit count; at count DATA_WIDTH → rx_data updated, rx_valid pulse, count = 0, stay ACTIVE (back-to-back words).
  - ACTIVE shift edge: if tx bit index = 0, perform load, drive first bit; else drive next bit.
  - Load: tx_valid=1 → capture tx_data, pulse tx_ready; tx_valid=0 → shifter = 0, pulse tx_underrun.
  - cs rise in ACTIVE: bit count ≠ 0 → frame_error pulse, partial word discarded; → IDLE, miso=0, miso_oe=0. An unconsumed preloaded word is dropped.
  - WAIT_CS_HIGH: entered from reset; → IDLE on first synchronized cs=1, so a frame in progress at reset release is ignored.
- cpha=0: a shift edge after the last sample of a word loads and drives the next word; a final trailing edge before cs rise consumes a word (expected master behavior).
- Mode inputs changing while ACTIVE: ignored.

## Timing
- Reset: miso, miso_oe, tx_ready, tx_underrun, rx_valid, frame_error = 0; rx_data = 0; FSM = WAIT_CS_HIGH; counters and shifters 0.
- Requirement: sclk half-period ≥ 4 pclk; cs-fall to first sclk edge ≥ 4 pclk.
- Edge pulse: 3rd pclk edge after an sclk/cs transition (2 sync + 1 detect).
- miso/miso_oe registered: update 1 pclk after edge pulse (4 pclk after pin transition).
- rx_valid: 1 pclk after final sample-edge pulse; rx_data valid same cycle.
- tx_ready/tx_underrun asserted in the same cycle as the load's edge pulse.
- Simultaneous cs rise and sample-edge pulse: cs rise wins; the sample is discarded.

## Structure
- spi_globals_pkg: FSM state enum, default DATA_WIDTH, mode struct {cpol, cpha, msb_first}.
- Sub-module spi_sync_edge_detect: 2-flop synchronizer + rise/fall pulse; instantiated for sclk and cs; mosi uses synchronizer only.

## Test plan
- Mode 0, MSB first, tx 0xA5 valid, master sends 0x3C → rx_data=0x3C, one rx_valid, master reads 0xA5, one tx_ready.
- All four modes × both bit orders, tx 0x81 / mosi 0x7E → correct bit alignment on both lines, timing per above.
- Two back-to-back words in one cs-low (mosi 0x11, 0x22; tx 0xF0, 0x0F) → two rx_valid pulses with 0x11 then 0x22; master reads 0xF0, 0x0F.
- tx_valid=0 at load → miso 0x00 for the word, tx_underrun one pulse, no tx_ready.
- cs rises after 5 of 8 bits → frame_error pulse, no rx_valid, rx_data retains prior value, miso=0, miso_oe=0.
- areset asserted mid-word with cs held low → outputs per reset; no frame activity until cs high then low again, which yields a normal frame.
